pc_gen: RTL and testbench



---
 rtl/pc_gen.sv | 169 ++++++++++++++++
 tb/tb_pc_gen.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// pc_gen: program-counter generator for the reduced RISC-V core.
//
// Produces the instruction fetch address each cycle. The PC advances by INC
// or jumps to a redirect target (branch, jalr, trap, trap return). If a
// redirect arrives while fetch is blocked, it is held in a one-entry pending
// buffer until the PC can advance.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   stall        pipeline hold; PC does not advance
//   fetch_ready  instruction memory accepts pc this cycle
//   pc_src       00 seq, 01 branch, 10 jalr, 11 seq
//   imm_op       sign-extended immediate
//   rs1_val      jalr base register value
//   trap_req     exception/interrupt request
//   ret_req      return from trap
//   pc           current fetch address
//   pc_valid     pc is a valid fetch request
//   pc_plus      pc+INC (link value), combinational
//   epc          saved return PC
//   misalign_err one-cycle pulse after a misaligned target is captured
module pc_gen #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = 32'h0000_0000,
  parameter logic [WIDTH-1:0] TRAP_VEC  = 32'h0000_0100,
  parameter int               INC       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             fetch_ready,
  input  logic [1:0]       pc_src,
  input  logic [WIDTH-1:0] imm_op,
  input  logic [WIDTH-1:0] rs1_val,
  input  logic             trap_req,
  input  logic             ret_req,
  output logic [WIDTH-1:0] pc,
  output logic             pc_valid,
  output logic [WIDTH-1:0] pc_plus,
  output logic [WIDTH-1:0] epc,
  output logic             misalign_err
);

  localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

  typedef enum logic [1:0] {BOOT, RUN, PEND} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic [WIDTH-1:0] pend_tgt_q, pend_tgt_d;
  logic             pend_trap_q, pend_trap_d;
  logic             misalign_q, misalign_d;

  logic             active, advance;
  logic [WIDTH-1:0] br_tgt, jalr_sum, jalr_tgt;
  logic             redir, redir_trap, mis_det, capture;
  logic [WIDTH-1:0] redir_tgt;

  // Redirect selection, highest priority first. Misaligned branch/jalr
  // targets turn into a trap to TRAP_VEC.
  always_comb begin
    active     = (state_q != BOOT);
    advance    = ~stall & fetch_ready & active;
    br_tgt     = pc_q + imm_op;
    jalr_sum   = rs1_val + imm_op;
    jalr_tgt   = {jalr_sum[WIDTH-1:1], 1'b0};
    redir      = 1'b0;
    redir_trap = 1'b0;
    mis_det    = 1'b0;
    redir_tgt  = '0;
    if (active) begin
      if (trap_req) begin
        redir      = 1'b1;
        redir_trap = 1'b1;
        redir_tgt  = TRAP_VEC;
      end else if (ret_req) begin
        redir     = 1'b1;
        redir_tgt = epc_q;
      end else if (pc_src == 2'b10) begin
        redir = 1'b1;
        if ((jalr_tgt % INC_W) != '0) begin
          redir_trap = 1'b1;
          mis_det    = 1'b1;
          redir_tgt  = TRAP_VEC;
        end else begin
          redir_tgt = jalr_tgt;
        end
      end else if (pc_src == 2'b01) begin
        redir = 1'b1;
        if ((br_tgt % INC_W) != '0) begin
          redir_trap = 1'b1;
          mis_det    = 1'b1;
          redir_tgt  = TRAP_VEC;
        end else begin
          redir_tgt = br_tgt;
        end
      end
    end
  end

  // Next-state logic. 'capture' marks a redirect that was actually taken,
  // either applied to pc or written into the pending buffer; only then do
  // epc and misalign_err react.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    epc_d       = epc_q;
    pend_tgt_d  = pend_tgt_q;
    pend_trap_d = pend_trap_q;
    capture     = 1'b0;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (advance) begin
          pc_d    = redir ? redir_tgt : pc_plus;
          capture = redir;
        end else if (redir) begin
          pend_tgt_d  = redir_tgt;
          pend_trap_d = redir_trap;
          state_d     = PEND;
          capture     = 1'b1;
        end
      end
      PEND: begin
        if (advance) begin
          pc_d        = redir ? redir_tgt : pend_tgt_q;
          pend_trap_d = 1'b0;
          state_d     = RUN;
          capture     = redir;
        end else if (redir && (!pend_trap_q || redir_trap)) begin
          // A held trap target can only be replaced by another trap.
          pend_tgt_d  = redir_tgt;
          pend_trap_d = redir_trap;
          capture     = 1'b1;
        end
      end
      default: state_d = BOOT;
    endcase
    if (capture && redir_trap) epc_d = pc_q;
    misalign_d = capture & mis_det;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= BOOT;
      pc_q        <= RESET_VEC;
      epc_q       <= RESET_VEC;
      pend_tgt_q  <= '0;
      pend_trap_q <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      epc_q       <= epc_d;
      pend_tgt_q  <= pend_tgt_d;
      pend_trap_q <= pend_trap_d;
      misalign_q  <= misalign_d;
    end
  end

  assign pc           = pc_q;
  assign pc_plus      = pc_q + INC_W;
  assign pc_valid     = (state_q != BOOT);
  assign epc          = epc_q;
  assign misalign_err = misalign_q;

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;
  logic        clk = 1'b0;
  logic        rst;
  logic        stall, fetch_ready, trap_req, ret_req;
  logic [1:0]  pc_src;
  logic [31:0] imm_op, rs1_val;
  logic [31:0] pc, pc_plus, epc;
  logic        pc_valid, misalign_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] epc;
    logic        mis;
  } exp_t;
  exp_t q[$];

  pc_gen dut (
    .clk(clk), .rst(rst), .stall(stall), .fetch_ready(fetch_ready),
    .pc_src(pc_src), .imm_op(imm_op), .rs1_val(rs1_val),
    .trap_req(trap_req), .ret_req(ret_req), .pc(pc), .pc_valid(pc_valid),
    .pc_plus(pc_plus), .epc(epc), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every cycle the DUT presents a valid pc, pop one expectation.
  always @(negedge clk) begin
    if (rst === 1'b1 && pc_valid === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid pc %h with empty queue", pc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("pc", pc, e.pc);
        chk("pc_plus", pc_plus, e.pc + 32'd4);
        chk("epc", epc, e.epc);
        chk("misalign_err", {31'd0, misalign_err}, {31'd0, e.mis});
      end
    end
  end

  // Drive one cycle of inputs and queue the outputs expected during it.
  task automatic step(input logic s, input logic fr, input logic [1:0] src,
                      input logic [31:0] imm, input logic [31:0] rs,
                      input logic tr, input logic rt,
                      input logic [31:0] ep, input logic [31:0] ee, input logic em);
    exp_t e;
    stall = s; fetch_ready = fr; pc_src = src; imm_op = imm; rs1_val = rs;
    trap_req = tr; ret_req = rt;
    e.pc = ep; e.epc = ee; e.mis = em;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; stall = 1'b0; fetch_ready = 1'b1; pc_src = 2'b00;
    imm_op = '0; rs1_val = '0; trap_req = 1'b0; ret_req = 1'b0;
    #1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_epc", epc, 32'h0);
    chk("rst_valid", {31'd0, pc_valid}, 32'd0);
    chk("rst_mis", {31'd0, misalign_err}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    // BOOT: stays put with pc_valid low until the next edge
    chk("boot_valid", {31'd0, pc_valid}, 32'd0);
    chk("boot_pc", pc, 32'h0);
    @(posedge clk); #1;

    // sequential run
    step(0,1,2'b00,0,0,0,0, 32'h00, 0, 0);
    step(0,1,2'b00,0,0,0,0, 32'h04, 0, 0);
    step(0,1,2'b00,0,0,0,0, 32'h08, 0, 0);
    step(0,1,2'b00,0,0,0,0, 32'h0C, 0, 0);
    // branch back: 0x10 - 8 = 0x08
    step(0,1,2'b01,32'hFFFF_FFF8,0,0,0, 32'h10, 0, 0);
    // jalr 0x101+3 = 0x104, bit0 cleared
    step(0,1,2'b10,32'h3,32'h101,0,0, 32'h08, 0, 0);
    // branch to 0x20
    step(0,1,2'b01,32'hFFFF_FF1C,0,0,0, 32'h104, 0, 0);
    // blocked fetch with branch -> pending 0x60
    step(0,0,2'b01,32'h40,0,0,0, 32'h20, 0, 0);
    step(0,0,2'b00,0,0,0,0, 32'h20, 0, 0);
    step(0,0,2'b00,0,0,0,0, 32'h20, 0, 0);
    step(0,0,2'b00,0,0,0,0, 32'h20, 0, 0);
    step(0,1,2'b00,0,0,0,0, 32'h20, 0, 0);
    // branch to 0x30
    step(0,1,2'b01,32'hFFFF_FFD0,0,0,0, 32'h60, 0, 0);
    // misaligned branch 0x32 -> trap vector, epc=0x30, one-cycle pulse
    step(0,1,2'b01,32'h2,0,0,0, 32'h30, 0, 0);
    step(0,1,2'b00,0,0,0,0, 32'h100, 32'h30, 1);
    step(0,1,2'b00,0,0,0,0, 32'h104, 32'h30, 0);
    // branch to 0x44
    step(0,1,2'b01,32'hFFFF_FF3C,0,0,0, 32'h108, 32'h30, 0);
    // trap+ret together: trap wins
    step(0,1,2'b00,0,0,1,1, 32'h44, 32'h30, 0);
    step(0,1,2'b00,0,0,0,1, 32'h100, 32'h44, 0);
    step(0,1,2'b00,0,0,0,0, 32'h44, 32'h44, 0);
    // pending trap is not displaced by a later branch
    step(0,0,2'b00,0,0,1,0, 32'h48, 32'h44, 0);
    step(0,0,2'b01,32'h10,0,0,0, 32'h48, 32'h48, 0);
    step(0,1,2'b00,0,0,0,0, 32'h48, 32'h48, 0);
    step(0,1,2'b00,0,0,0,0, 32'h100, 32'h48, 0);
    // stall holds pc
    step(1,1,2'b00,0,0,0,0, 32'h104, 32'h48, 0);
    step(0,1,2'b00,0,0,0,0, 32'h104, 32'h48, 0);
    // branch to 0xFFFF_FFFC, then wrap to 0
    step(0,1,2'b01,32'hFFFF_FEF4,0,0,0, 32'h108, 32'h48, 0);
    step(0,1,2'b00,0,0,0,0, 32'hFFFF_FFFC, 32'h48, 0);
    step(0,1,2'b00,0,0,0,0, 32'h0, 32'h48, 0);
    // branch to 0x80
    step(0,1,2'b01,32'h7C,0,0,0, 32'h04, 32'h48, 0);
    chk("pre_reset_pc", pc, 32'h80);
    // async reset between edges
    #2 rst = 1'b0;
    #1;
    chk("async_pc", pc, 32'h0);
    chk("async_valid", {31'd0, pc_valid}, 32'd0);
    chk("async_epc", epc, 32'h0);
    @(posedge clk); #1;
    chk("queue_drained", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
